// File: rtl/gcd_share_arbiter.sv
// Round-robin arbiter sharing one GCD engine among N requesters.
// Latches the winner's operands, pulses eng_start, captures eng_gcd and
// returns it with a one-cycle resp_valid strobe to the granted requester.
// Optional build macro GCD_ARB_TIMEOUT_EN adds a BUSY watchdog, the resp_err
// output and an ABORT state that swallows the late engine result.
module gcd_share_arbiter #(
  parameter int unsigned N              = 4,
  parameter int unsigned IDW            = 2,
  parameter int unsigned TIMEOUT_CYCLES = 70000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [16*N-1:0] req_a,
  input  logic [16*N-1:0] req_b,
  output logic [N-1:0]    resp_valid,
  output logic [15:0]     resp_gcd,
`ifdef GCD_ARB_TIMEOUT_EN
  output logic            resp_err,
`endif
  output logic            busy,
  output logic [IDW-1:0]  grant_id,
  output logic            eng_start,
  output logic [15:0]     eng_a,
  output logic [15:0]     eng_b,
  input  logic            eng_done,
  input  logic [15:0]     eng_gcd
);

  // Elaboration-time parameter sanity checks
  if (N < 2 || N > 8) begin : g_bad_n
    $error("gcd_share_arbiter: N must be 2..8");
  end
  if ((1 << IDW) < N) begin : g_bad_idw
    $error("gcd_share_arbiter: IDW too narrow for N");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES >= (1 << 17)) begin : g_bad_to
    $error("gcd_share_arbiter: TIMEOUT_CYCLES must fit the 17-bit watchdog");
  end

  typedef enum logic [2:0] {StIdle, StStart, StBusy, StResp, StDrain, StAbort} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [15:0]    a_q, a_d, b_q, b_d;
  logic [15:0]    gcd_q, gcd_d;
`ifdef GCD_ARB_TIMEOUT_EN
  logic [16:0]    wdog_q, wdog_d;
  logic           err_q, err_d;
`endif

  logic        found;
  int unsigned win_idx;

  // Round-robin search: first set req bit at or above the pointer, wrapping
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[(32'(ptr_q) + k) % N]) begin
        found   = 1'b1;
        win_idx = (32'(ptr_q) + k) % N;
      end
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
`ifdef GCD_ARB_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A done still high from an earlier job must not overlap a new start
        if (found && !eng_done) begin
          a_d     = req_a[16*win_idx +: 16];
          b_d     = req_b[16*win_idx +: 16];
          grant_d = IDW'(win_idx);
          ptr_d   = IDW'((win_idx + 1) % N);
          state_d = StStart;
        end
      end
      StStart: begin
`ifdef GCD_ARB_TIMEOUT_EN
        wdog_d = '0;
`endif
        state_d = StBusy;
      end
      StBusy: begin
        if (eng_done) begin
          gcd_d   = eng_gcd;
`ifdef GCD_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StResp;
`ifdef GCD_ARB_TIMEOUT_EN
        end else if (wdog_q == 17'(TIMEOUT_CYCLES - 1)) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wdog_d = wdog_q + 17'd1;
`endif
        end
      end
      StResp: begin
`ifdef GCD_ARB_TIMEOUT_EN
        state_d = err_q ? StAbort : StDrain;
`else
        state_d = StDrain;
`endif
      end
      StAbort: begin
        // Late result from the engine is discarded
        if (eng_done) state_d = StDrain;
      end
      StDrain: begin
        if (!eng_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
`ifdef GCD_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  // Response strobe decoded from state and grant
  always_comb begin
    resp_valid = '0;
    if (state_q == StResp) resp_valid[grant_q] = 1'b1;
  end

  assign resp_gcd  = gcd_q;
  assign busy      = (state_q != StIdle);
  assign grant_id  = grant_q;
  assign eng_start = (state_q == StStart);
  assign eng_a     = a_q;
  assign eng_b     = b_q;
`ifdef GCD_ARB_TIMEOUT_EN
  assign resp_err  = err_q && (state_q == StResp);
`endif

endmodule

// File: tb/tb_gcd_share_arbiter.sv
// Directed bench for gcd_share_arbiter with a behavioural GCD engine.
module tb_gcd_share_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
`ifdef GCD_ARB_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 70000;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]    resp_valid;
  logic [15:0]     resp_gcd;
  logic            busy;
  logic [IDW-1:0]  grant_id;
  logic            eng_start;
  logic [15:0]     eng_a, eng_b;
  logic            eng_done;
  logic [15:0]     eng_gcd;
`ifdef GCD_ARB_TIMEOUT_EN
  logic            resp_err;
`endif

  gcd_share_arbiter #(.N(N), .IDW(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_gcd(resp_gcd),
`ifdef GCD_ARB_TIMEOUT_EN
    .resp_err(resp_err),
`endif
    .busy(busy), .grant_id(grant_id), .eng_start(eng_start),
    .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_gcd(eng_gcd)
  );

  always #5 clk = ~clk;

  // Engine model: done high for two cycles, eng_lat cycles after start
  int eng_lat = 4;
  function automatic logic [15:0] euclid(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  initial begin
    logic [15:0] ea, eb;
    eng_done = 1'b0;
    eng_gcd  = '0;
    forever begin
      @(posedge clk); #2;
      if (eng_start) begin
        ea = eng_a;
        eb = eng_b;
        repeat (eng_lat) @(posedge clk);
        #2;
        eng_gcd  = euclid(ea, eb);
        eng_done = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        eng_done = 1'b0;
      end
    end
  end

  // Monitor sampled 1 time unit after each rising edge
  int   cyc = 0, start_cnt = 0, done_cyc = -1, resp_cyc = -1;
  int   pulse_cnt [N] = '{default: 0};
  logic done_prev = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (eng_start) start_cnt++;
      if (eng_done && !done_prev) done_cyc = cyc;
      done_prev = eng_done;
      for (int i = 0; i < N; i++) if (resp_valid[i]) pulse_cnt[i]++;
      if (resp_valid != 0) resp_cyc = cyc;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_resp(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !eng_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
  } vec_t;
  vec_t vecs [9];

  // Global time bound so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int n, snap, snap1;
    logic [IDW-1:0] prev_gid;
    logic [15:0] exp_g [4];

    vecs[0] = '{1, 16'd48, 16'd18, 16'd6};
    vecs[1] = '{0, 16'd12, 16'd8, 16'd4};
    vecs[2] = '{2, 16'd35, 16'd14, 16'd7};
    vecs[3] = '{3, 16'd0, 16'd9, 16'd9};
    vecs[4] = '{1, 16'd9, 16'd0, 16'd9};
    vecs[5] = '{0, 16'd0, 16'd0, 16'd0};
    vecs[6] = '{2, 16'd17, 16'd5, 16'd1};
    vecs[7] = '{3, 16'd65535, 16'd65535, 16'd65535};
    vecs[8] = '{0, 16'd1071, 16'd462, 16'd21};

    rst = 1'b1; req = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_gcd", 32'(resp_gcd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_eng_a", 32'(eng_a), 0);
    check("rst_eng_b", 32'(eng_b), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-requester vectors
    for (int v = 0; v < 9; v++) begin
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      req[vecs[v].idx] = 1'b1;
      snap = start_cnt;
      @(negedge clk);
      check("start_latency", 32'(eng_start), 1);
      check("eng_a", 32'(eng_a), 32'(vecs[v].a));
      check("eng_b", 32'(eng_b), 32'(vecs[v].b));
      @(negedge clk);
      check("start_one_cycle", 32'(eng_start), 0);
      wait_resp(ok, n);
      check("resp_seen", 32'(ok), 1);
      check("resp_valid", 32'(resp_valid), 32'(1 << vecs[v].idx));
      check("resp_gcd", 32'(resp_gcd), 32'(vecs[v].g));
      check("grant_id", 32'(grant_id), 32'(vecs[v].idx));
      check("resp_after_done", 32'(resp_cyc - done_cyc), 0);
      req[vecs[v].idx] = 1'b0;
      wait_idle(ok);
      check("idle_after_drain", 32'(ok), 1);
      check("single_start", 32'(start_cnt - snap), 1);
      check("resp_gcd_hold", 32'(resp_gcd), 32'(vecs[v].g));
    end

    // All four requesters at once: grants 0,1,2,3
    do_reset();
    set_ops(0, 16'd12, 16'd8);
    set_ops(1, 16'd35, 16'd14);
    set_ops(2, 16'd17, 16'd5);
    set_ops(3, 16'd0, 16'd9);
    exp_g = '{16'd4, 16'd7, 16'd1, 16'd9};
    snap = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_resp(ok, n);
      check("all_resp_seen", 32'(ok), 1);
      check("all_grant", 32'(grant_id), k);
      check("all_valid", 32'(resp_valid), 32'(1 << k));
      check("all_gcd", 32'(resp_gcd), 32'(exp_g[k]));
      req[k] = 1'b0;
    end
    wait_idle(ok);
    check("all_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - snap, 4);

    // Fairness: req[0] and req[2] held, new operands after each response
    do_reset();
    set_ops(0, 16'd12, 16'd8);
    set_ops(2, 16'd35, 16'd14);
    exp_g = '{16'd4, 16'd7, 16'd2, 16'd9};
    req = 4'b0101;
    prev_gid = 2'd3;
    for (int j = 0; j < 4; j++) begin
      wait_resp(ok, n);
      check("fair_resp_seen", 32'(ok), 1);
      check("fair_grant", 32'(grant_id), (j % 2 == 0) ? 0 : 2);
      check("fair_not_repeat", 32'(grant_id != prev_gid), 1);
      check("fair_gcd", 32'(resp_gcd), 32'(exp_g[j]));
      prev_gid = grant_id;
      if (j == 0) set_ops(0, 16'd10, 16'd4);
      if (j == 1) set_ops(2, 16'd27, 16'd18);
      if (j == 3) req = '0;
    end
    wait_idle(ok);

    // Operands changed after grant are ignored
    set_ops(3, 16'd100, 16'd75);
    req[3] = 1'b1;
    @(negedge clk);
    check("chg_start", 32'(eng_start), 1);
    @(negedge clk);
    set_ops(3, 16'd1, 16'd1);
    @(negedge clk);
    check("chg_eng_a", 32'(eng_a), 100);
    check("chg_eng_b", 32'(eng_b), 75);
    wait_resp(ok, n);
    check("chg_gcd", 32'(resp_gcd), 25);
    req[3] = 1'b0;
    wait_idle(ok);

    // Reset during BUSY, then a stale done must not trigger a grant
    eng_lat = 12;
    set_ops(1, 16'd40, 16'd16);
    req[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_resp_valid", 32'(resp_valid), 0);
    check("arst_resp_gcd", 32'(resp_gcd), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_grant", 32'(grant_id), 0);
    check("arst_eng_start", 32'(eng_start), 0);
    check("arst_eng_a", 32'(eng_a), 0);
    check("arst_eng_b", 32'(eng_b), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    snap1 = pulse_cnt[1];
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (eng_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("stale_done_seen", 32'(ok), 1);
    eng_lat = 4;
    set_ops(2, 16'd21, 16'd6);
    req[2] = 1'b1;
    snap = pulse_cnt[2];
    @(negedge clk);
    check("stale_done_blocks", 32'(busy), 0);
    wait_resp(ok, n);
    check("post_rst_resp_seen", 32'(ok), 1);
    check("post_rst_valid", 32'(resp_valid), 32'(4'b0100));
    check("post_rst_gcd", 32'(resp_gcd), 3);
    check("post_rst_latency", 32'(resp_cyc - done_cyc), 0);
    req[2] = 1'b0;
    wait_idle(ok);
    check("post_rst_pulse", pulse_cnt[2] - snap, 1);
    check("stale_no_resp", pulse_cnt[1] - snap1, 0);

`ifdef GCD_ARB_TIMEOUT_EN
    // Watchdog: engine too slow, error response then late result discarded
    eng_lat = 30;
    set_ops(0, 16'd65535, 16'd1);
    req[0] = 1'b1;
    snap = pulse_cnt[0];
    @(negedge clk);
    check("to_start", 32'(eng_start), 1);
    wait_resp(ok, n);
    check("to_resp_seen", 32'(ok), 1);
    check("to_busy_cycles", n, TO + 1);
    check("to_valid", 32'(resp_valid), 32'(4'b0001));
    check("to_err", 32'(resp_err), 1);
    check("to_gcd", 32'(resp_gcd), 0);
    req[0] = 1'b0;
    @(negedge clk);
    check("to_err_pulse", 32'(resp_err), 0);
    check("to_abort_busy", 32'(busy), 1);
    wait_idle(ok);
    check("to_idle", 32'(ok), 1);
    check("to_late_discard", pulse_cnt[0] - snap, 1);
    check("to_gcd_kept", 32'(resp_gcd), 0);
    eng_lat = 4;
    set_ops(1, 16'd9, 16'd6);
    req[1] = 1'b1;
    wait_resp(ok, n);
    check("to_next_gcd", 32'(resp_gcd), 3);
    check("to_next_err", 32'(resp_err), 0);
    req[1] = 1'b0;
    wait_idle(ok);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_share_arbiter.md
Name: gcd_share_arbiter

Overview:
- Shares one Greatest_Common_Divisor engine (start/a/b in; done/gcd out) among N requesters.
- Arbitration is round-robin.
- The block latches the granted operands, pulses the engine start, captures the result and returns it to the owning requester with a one-cycle response strobe.
- It sits between the requester ports and the single GCD datapath instance, and is the only driver of the engine's start, a and b.

Parameters:
N, 4, number of requesters (2..8)
IDW, 2, width of grant_id; must satisfy 2**IDW >= N
TIMEOUT_CYCLES, 70000, watchdog limit in BUSY (used only with GCD_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  N  request per requester; held high until its resp_valid bit pulses
req_a  in  16*N  operand A, requester i in bits [16*i+15:16*i]; stable while req[i] is high
req_b  in  16*N  operand B, same packing as req_a
resp_valid  out  N  one-cycle strobe to the served requester
resp_gcd  out  16  result; valid while any resp_valid bit is high
busy  out  1  high whenever state != IDLE
grant_id  out  IDW  index of the current or last served requester
eng_start  out  1  engine start, one-cycle pulse
eng_a  out  16  latched operand A to the engine
eng_b  out  16  latched operand B to the engine
eng_done  in  1  engine done (high for 2 cycles per job)
eng_gcd  in  16  engine result; valid while eng_done is high

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; resp_valid=0, resp_gcd=0, busy=0, grant_id=0.
  - eng_start=0, eng_a=0, eng_b=0.
  - RR pointer=0, so requester 0 has highest priority first.
- States: IDLE, START, BUSY, RESP, DRAIN (plus ABORT with the optional feature).
- IDLE:
  - Arbitration happens only when req != 0 and eng_done == 0.
  - Winner = first set req bit searching from the pointer upward, with wrap-around.
  - On the arbitration edge: latch req_a/req_b slices into eng_a/eng_b, set grant_id=winner, pointer=(winner+1) mod N, go to START.
- START:
  - eng_start=1 for exactly this cycle; eng_a/eng_b are stable.
  - Next state is BUSY.
- BUSY:
  - eng_start=0.
  - On the first cycle eng_done==1: register eng_gcd into resp_gcd, go to RESP.
- RESP:
  - resp_valid[grant_id]=1 for one cycle; all other bits stay 0.
  - Next state is DRAIN.
- DRAIN:
  - Wait for eng_done==0, then go to IDLE.
  - This guarantees the engine is back in WAIT before the next start.
- Latency:
  - Arbitration edge to eng_start: 1 cycle.
  - First eng_done high to resp_valid: 1 cycle.
  - Minimum turnaround between two grants: 5 cycles plus engine compute time.
- Requester rules:
  - A requester drops req within 1 cycle after its resp_valid. If req is still high when IDLE is re-entered, it is treated as a new request.
  - Changing req_a/req_b while granted has no effect; the operands were latched at grant.
- Simultaneous requests:
  - Exactly one grant per arbitration; the others wait.
  - No requester waits more than N-1 grants.
- Zero operands:
  - Passed through unchanged.
  - gcd(0,x)=x; gcd(0,0)=0, as produced by the engine.
- Result register:
  - resp_gcd holds its value until the next capture.
  - It is not cleared after RESP.
- Reset mid-operation:
  - The arbiter returns to IDLE immediately.
  - A stale eng_done pulse from the engine is absorbed by the IDLE eng_done==0 qualification.

Optional Feature:
- Macro: GCD_ARB_TIMEOUT_EN.
- When defined:
  - Adds output port resp_err (1 bit) and a 17-bit watchdog counter.
  - The counter is cleared on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES before eng_done: pulse resp_valid[grant_id] with resp_err=1 and resp_gcd=0, then enter ABORT.
  - ABORT waits for eng_done==1, discards the late result, then goes to DRAIN.
  - resp_err=0 on every normal response; reset value is 0.
- When undefined:
  - No resp_err port, no counter, no ABORT state.
  - BUSY waits for eng_done indefinitely.

Test Plan:
- Single request, req[1]=1, a=48, b=18 → one eng_start pulse with eng_a=48, eng_b=18; resp_valid=4'b0010 for 1 cycle with resp_gcd=6; busy returns to 0 after DRAIN.
- All four requesters high at once after reset, operands (12,8), (35,14), (17,5), (0,9):
  - Grants in order 0,1,2,3.
  - Results 4, 7, 1, 9.
  - Each resp_valid bit pulses exactly once.
- Fairness: req[0] and req[2] held continuously with new operands after each response → grant_id alternates 0,2,0,2; no requester is served twice in a row.
- Operands change after grant: req[3] with a=100, b=75, then a/b changed to 1,1 during BUSY → resp_gcd=25.
- Reset asserted during BUSY → all outputs reach reset values asynchronously; after release, a new request (21,6) returns 3 with correct single-pulse timing.
- With GCD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, request a=65535, b=1:
  - resp_err=1 and resp_gcd=0 after 10 BUSY cycles.
  - The arbiter then waits for the engine's done and discards it.
  - A subsequent (9,6) request returns 3 with resp_err=0.
